bpf_alu_ctrl: RTL
=================

Name: bpf_alu_ctrl

Overview:
- Accumulator-style execution controller for the 8-bit BPF datapath.
- Accepts one instruction at a time over a valid/ready handshake and holds the BPF A (accumulator) and X (index) registers.
- Drives the combinational 8-bit ALU's operand and opcode inputs, captures the ALU result into A, and returns the new A over a second valid/ready handshake.
- Sits between the instruction sequencer and the ALU. It is the issuing side of the ALU's op/i1/i2/o interface.

Parameters:
- ALU_LAT, 1: cycles alu_* are held before alu_o is sampled; legal range 1..15.
- A_RST, 8'h00: reset value of A.
- X_RST, 8'h00: reset value of X.

Ports:
- clk  input  1  rising-edge clock; the block's only clock.
- rst  input  1  reset: synchronous, active-high.
- in_valid  input  1  instruction present.
- in_ready  output  1  controller can accept an instruction.
- in_op  input  8  instruction code (see Behaviour).
- in_src  input  1  second operand select: 0 = in_imm, 1 = X.
- in_imm  input  8  immediate operand.
- alu_op  output  8  ALU opcode.
- alu_i1  output  8  ALU operand 1, always A.
- alu_i2  output  8  ALU operand 2, in_imm or X.
- alu_o  input  8  ALU result.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_a  output  8  value of A after the instruction.
- out_err  output  1  instruction faulted; qualified by out_valid.

Behaviour:
- Reset values: state=IDLE, A=A_RST, X=X_RST, in_ready=1, out_valid=0, out_err=0, out_a=A_RST, alu_op=0, alu_i1=0, alu_i2=0, wait counter=0.
- Reset mid-instruction aborts it; nothing is captured.
- in_op codes:
  - 1 ADD, 2 SUB, 3 MUL, 4 DIV, 5 AND, 6 OR, 7 NOT: ALU ops, passed through unchanged on alu_op.
  - 8 LDA: A <= src.
  - 9 LDX: X <= src.
  - 10 TAX: X <= A.
  - 11 TXA: A <= X.
  - All other codes are illegal.
- src means in_imm when in_src=0, X when in_src=1.
- States: IDLE, EXEC, RESP.
- IDLE:
  - in_ready=1. Accept occurs on in_valid && in_ready.
  - ALU op with no fault: register alu_op=in_op, alu_i1=A, alu_i2=src; load counter with ALU_LAT; go to EXEC.
  - DIV with src==0: fault.
  - Illegal code: fault.
  - Fault handling: A and X unchanged, out_err=1, no ALU issue, go to RESP.
  - Codes 8-11: update A/X at the accept edge, out_err=0, go to RESP.
- EXEC:
  - in_ready=0; alu_* held stable.
  - Counter decrements each cycle.
  - On the edge where the counter reaches 1: A <= alu_o, alu_op <= 0, go to RESP.
- RESP:
  - out_valid=1; out_a = current A (post-update); out_err as set.
  - out_a and out_err are held stable until out_valid && out_ready, then go to IDLE.
  - in_ready=0 throughout RESP; there is no back-to-back overlap.
- Latency:
  - ALU op: out_valid rises ALU_LAT+1 cycles after the accept edge.
  - Non-ALU op or fault: out_valid rises 1 cycle after the accept edge.
- Width rules: all arithmetic is 8-bit modulo, as produced by the ALU; the controller never widens or saturates. NOT ignores alu_i2, but alu_i2 is still driven with src.
- in_valid asserted while in_ready=0 is ignored; the sender must hold the instruction.
- out_ready asserted while out_valid=0 has no effect.
- alu_op is 0 in every cycle outside EXEC, so the ALU outputs 0.

Optional Feature:
- Macro: BPF_ALU_CTRL_STATS_EN.
- When defined, two extra outputs are added:
  - op_count (16 bits): increments on each completed response handshake.
  - err_count (8 bits): increments on each completed response handshake with out_err=1.
- Both counters saturate at their maximum and reset to 0 on rst.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then LDA imm 8'h05 -> out_valid 1 cycle after accept, out_a=8'h05, out_err=0, alu_op stays 0.
- A=8'hF0, ADD imm 8'h20, ALU_LAT=1 -> alu_op=1, alu_i1=8'hF0, alu_i2=8'h20 held 1 cycle; out_a=8'h10 (wrap), out_valid 2 cycles after accept.
- LDX imm 8'h00, then DIV with in_src=1 -> out_err=1, A unchanged, alu_op never 4.
- in_op=8'h0C -> out_err=1 after 1 cycle, A and X unchanged.
- Back-pressure: hold out_ready=0 for 5 cycles after MUL 8'h03×8'h04 -> out_a=8'h0C and out_valid held stable, in_ready=0 throughout; a second in_valid is not accepted until the cycle after the handshake.
- Assert rst during EXEC of SUB -> next cycle state IDLE, A=A_RST, out_valid=0, in_ready=1.

Source files
------------

// File: rtl/bpf_alu_ctrl_if.sv
// bpf_alu_ctrl_if: instruction, ALU-issue and response handshake bundle of the BPF execution controller.
interface bpf_alu_ctrl_if;
    logic       in_valid, in_ready, in_src, out_valid, out_ready, out_err;
    logic [7:0] in_op, in_imm, alu_op, alu_i1, alu_i2, alu_o, out_a;
    modport master (
        output in_valid, in_op, in_src, in_imm, alu_o, out_ready,
        input  in_ready, alu_op, alu_i1, alu_i2, out_valid, out_a, out_err
    );
    modport slave (
        input  in_valid, in_op, in_src, in_imm, alu_o, out_ready,
        output in_ready, alu_op, alu_i1, alu_i2, out_valid, out_a, out_err
    );
endinterface

// File: rtl/bpf_alu_ctrl.sv
// bpf_alu_ctrl: BPF A/X accumulator controller issuing ops to an 8-bit combinational ALU.
// Define BPF_ALU_CTRL_STATS_EN to add saturating op_count/err_count outputs.
module bpf_alu_ctrl #(
    parameter int         ALU_LAT = 1,
    parameter logic [7:0] A_RST   = 8'h00,
    parameter logic [7:0] X_RST   = 8'h00
) (
    input logic clk,
    input logic rst,
    bpf_alu_ctrl_if.slave bus
`ifdef BPF_ALU_CTRL_STATS_EN
    ,
    output logic [15:0] op_count,
    output logic [7:0]  err_count
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t     state, state_n;
    logic [7:0] a, a_n, x, x_n, op, op_n, i1, i1_n, i2, i2_n, src;
    logic [3:0] cnt, cnt_n;
    logic       err, err_n, is_alu, is_ld, fault;
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == RESP;
    assign bus.out_a     = a;
    assign bus.out_err   = err;
    assign bus.alu_op    = op;
    assign bus.alu_i1    = i1;
    assign bus.alu_i2    = i2;
    always_comb begin
        src     = bus.in_src ? x : bus.in_imm;
        is_alu  = bus.in_op inside {[8'd1:8'd7]};
        is_ld   = bus.in_op inside {[8'd8:8'd11]};
        fault   = !(is_alu || is_ld) || (bus.in_op == 8'd4 && src == 8'd0);
        state_n = state;
        a_n     = a;
        x_n     = x;
        op_n    = op;
        i1_n    = i1;
        i2_n    = i2;
        cnt_n   = cnt;
        err_n   = err;
        case (state)
            IDLE: if (bus.in_valid) begin
                state_n = (is_alu && !fault) ? EXEC : RESP;
                err_n   = fault;
                if (is_alu && !fault) begin
                    op_n  = bus.in_op;
                    i1_n  = a;
                    i2_n  = src;
                    cnt_n = 4'(ALU_LAT);
                end
                if (is_ld) begin
                    a_n = bus.in_op == 8'd8 ? src : bus.in_op == 8'd11 ? x : a;
                    x_n = bus.in_op == 8'd9 ? src : bus.in_op == 8'd10 ? a : x;
                end
            end
            EXEC: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    a_n     = bus.alu_o;
                    op_n    = 8'd0;
                    state_n = RESP;
                end
            end
            RESP: state_n = bus.out_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a     <= A_RST;
            x     <= X_RST;
            op    <= 8'd0;
            i1    <= 8'd0;
            i2    <= 8'd0;
            cnt   <= 4'd0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            a     <= a_n;
            x     <= x_n;
            op    <= op_n;
            i1    <= i1_n;
            i2    <= i2_n;
            cnt   <= cnt_n;
            err   <= err_n;
        end
    end
`ifdef BPF_ALU_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            op_count  <= 16'd0;
            err_count <= 8'd0;
        end else if (state == RESP && bus.out_ready) begin
            if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
            if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
`endif
endmodule
